// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: RV32I funct3 encodings and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane handling for the load/store controller: request legality check,
// load extract/extend and sub-word store merge. Purely combinational.
import lsu_pkg::*;

module lsu_align (
    input  logic [2:0]  chk_funct3,
    input  logic [1:0]  chk_lane,
    input  logic        chk_we,
    output logic        chk_err,
    input  logic [2:0]  op_funct3,
    input  logic [1:0]  op_lane,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        chk_err = 1'b0;
        if (chk_we) begin
            case (chk_funct3)
                F3_B:    chk_err = 1'b0;
                F3_H:    chk_err = chk_lane[0];
                F3_W:    chk_err = |chk_lane;
                default: chk_err = 1'b1;
            endcase
        end else begin
            case (chk_funct3)
                F3_B, F3_BU: chk_err = 1'b0;
                F3_H, F3_HU: chk_err = chk_lane[0];
                F3_W:        chk_err = |chk_lane;
                default:     chk_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        sel_byte = word[{op_lane, 3'b000} +: 8];
        sel_half = op_lane[1] ? word[31:16] : word[15:0];
        case (op_funct3)
            F3_B:    rdata = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   rdata = {24'd0, sel_byte};
            F3_H:    rdata = {{16{sel_half[15]}}, sel_half};
            F3_HU:   rdata = {16'd0, sel_half};
            F3_W:    rdata = word;
            default: rdata = 32'd0;
        endcase
    end

    // Untouched lanes keep the word read back from memory.
    always_comb begin
        merged = word;
        case (op_funct3)
            F3_B: merged[{op_lane, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (op_lane[1]) merged[31:16] = wdata[15:0];
                else            merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu_ctrl.sv
// Load/store controller between the core memory stage and a word-wide synchronous data memory.
// Sub-word stores are done as read-modify-write; all outputs are registered.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a request, req_ready high, mem_addr 0
// READ     | word address on mem_addr, memory read in flight
// CAPTURE  | mem_dout valid; extract load data or merge store data
// WRITE    | mem_we high with final word on mem_din
// DONE     | one-cycle response pulse, then back to IDLE
import lsu_pkg::*;

module mem_lsu_ctrl #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    lsu_state_t            state;
    logic [ADDR_WIDTH-1:0] op_waddr;
    logic [1:0]            op_lane;
    logic [2:0]            op_funct3;
    logic                  op_we;
    logic [DATA_WIDTH-1:0] op_wdata;

    logic                  align_err;
    logic                  out_of_range;
    logic                  req_err;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merged_word;

    assign out_of_range = |req_addr[31:ADDR_WIDTH+2];
    assign req_err      = align_err | out_of_range;

    lsu_align u_align (
        .chk_funct3 (req_funct3),
        .chk_lane   (req_addr[1:0]),
        .chk_we     (req_we),
        .chk_err    (align_err),
        .op_funct3  (op_funct3),
        .op_lane    (op_lane),
        .word       (mem_dout),
        .wdata      (op_wdata),
        .rdata      (load_data),
        .merged     (merged_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            op_waddr   <= '0;
            op_lane    <= 2'd0;
            op_funct3  <= 3'd0;
            op_we      <= 1'b0;
            op_wdata   <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_we     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        op_waddr  <= req_addr[ADDR_WIDTH+1:2];
                        op_lane   <= req_addr[1:0];
                        op_funct3 <= req_funct3;
                        op_we     <= req_we;
                        op_wdata  <= req_wdata;
                        if (req_err) begin
                            state      <= ST_DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_we && req_funct3 == F3_W) begin
                            state    <= ST_WRITE;
                            mem_we   <= 1'b1;
                            mem_din  <= req_wdata;
                            mem_addr <= req_addr[ADDR_WIDTH+1:2];
                        end else begin
                            state    <= ST_READ;
                            mem_addr <= req_addr[ADDR_WIDTH+1:2];
                        end
                    end
                end
                ST_READ: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (op_we) begin
                        state   <= ST_WRITE;
                        mem_we  <= 1'b1;
                        mem_din <= merged_word;
                    end else begin
                        state      <= ST_DONE;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                        mem_addr   <= '0;
                    end
                end
                ST_WRITE: begin
                    state      <= ST_DONE;
                    resp_valid <= 1'b1;
                    mem_addr   <= '0;
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    mem_addr  <= '0;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    mem_addr  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Directed bench for mem_lsu_ctrl with a behavioural word memory attached.
module tb_mem_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic [31:0] mem [0:8191];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    mem_lsu_ctrl #(.ADDR_WIDTH(13), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Issue one request and follow it to its response pulse.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_we, input logic [31:0] exp_maddr);
        int lat;
        int we_cnt;
        logic [31:0] first_addr;
        lat    = 99;
        we_cnt = 0;
        first_addr = '0;
        @(negedge clk);
        check_eq({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) first_addr = {19'd0, mem_addr};
            if (mem_we) we_cnt++;
            if (resp_valid) begin
                lat = c;
                check_eq({tag, ".rdata"}, resp_rdata, exp_rdata);
                check_eq({tag, ".err"}, {31'd0, resp_err}, {31'd0, exp_err});
                break;
            end
        end
        check_eq({tag, ".lat"}, lat, exp_lat);
        check_eq({tag, ".we_cnt"}, we_cnt, exp_we);
        check_eq({tag, ".maddr"}, first_addr, exp_maddr);
    endtask

    initial begin
        int acc_cnt;
        int rv_cnt;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (3) @(negedge clk);
        check_eq("rst.ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst.mem_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst.mem_addr", {19'd0, mem_addr}, 32'd0);
        check_eq("rst.mem_din", mem_din, 32'd0);
        check_eq("rst.rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_req("sw0",  1, 3'b010, 32'h0, 32'h12345678, 2, 32'h0, 0, 1, 32'h0);
        check_eq("mem0.sw", mem[0], 32'h12345678);
        do_req("lw0",  0, 3'b010, 32'h0, 32'h0, 3, 32'h12345678, 0, 0, 32'h0);

        do_req("sb1",  1, 3'b000, 32'h1, 32'hFFFFFFAB, 4, 32'h0, 0, 1, 32'h0);
        check_eq("mem0.sb", mem[0], 32'h1234AB78);
        do_req("lb1",  0, 3'b000, 32'h1, 32'h0, 3, 32'hFFFFFFAB, 0, 0, 32'h0);
        do_req("lbu1", 0, 3'b100, 32'h1, 32'h0, 3, 32'h000000AB, 0, 0, 32'h0);

        do_req("sw4",  1, 3'b010, 32'h4, 32'h87654321, 2, 32'h0, 0, 1, 32'h1);
        do_req("sh6",  1, 3'b001, 32'h6, 32'h00008001, 4, 32'h0, 0, 1, 32'h1);
        check_eq("mem1.sh", mem[1], 32'h80014321);
        do_req("lh6",  0, 3'b001, 32'h6, 32'h0, 3, 32'hFFFF8001, 0, 0, 32'h1);
        do_req("lhu6", 0, 3'b101, 32'h6, 32'h0, 3, 32'h00008001, 0, 0, 32'h1);
        do_req("lb4",  0, 3'b000, 32'h4, 32'h0, 3, 32'h00000021, 0, 0, 32'h1);

        do_req("e.lw2",  0, 3'b010, 32'h2, 32'h0, 1, 32'h0, 1, 0, 32'h0);
        do_req("e.lh3",  0, 3'b001, 32'h3, 32'h0, 1, 32'h0, 1, 0, 32'h0);
        do_req("e.sw5",  1, 3'b010, 32'h5, 32'hDEADBEEF, 1, 32'h0, 1, 0, 32'h0);
        do_req("e.ld011", 0, 3'b011, 32'h0, 32'h0, 1, 32'h0, 1, 0, 32'h0);
        do_req("e.st100", 1, 3'b100, 32'h0, 32'h11111111, 1, 32'h0, 1, 0, 32'h0);
        check_eq("mem0.err", mem[0], 32'h1234AB78);
        check_eq("mem1.err", mem[1], 32'h80014321);

        do_req("e.oor",  0, 3'b010, 32'h8000, 32'h0, 1, 32'h0, 1, 0, 32'h0);
        do_req("sw_top", 1, 3'b010, 32'h7FFC, 32'hCAFEF00D, 2, 32'h0, 0, 1, 32'h1FFF);
        do_req("lw_top", 0, 3'b010, 32'h7FFC, 32'h0, 3, 32'hCAFEF00D, 0, 0, 32'h1FFF);

        // Abort an SB while its write is pending.
        rv_cnt = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h000000FF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) rv_cnt++;
        end
        check_eq("abort.we_before", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort.we_drop", {31'd0, mem_we}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            if (resp_valid) rv_cnt++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) rv_cnt++;
        end
        check_eq("abort.mem0", mem[0], 32'h1234AB78);
        check_eq("abort.ready", {31'd0, req_ready}, 32'd1);
        check_eq("abort.no_resp", rv_cnt, 0);

        // Hold req_valid through a busy load: only one accept expected.
        acc_cnt = 0;
        rv_cnt  = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h4;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            if (resp_valid) begin
                rv_cnt++;
                check_eq("hold.rdata", resp_rdata, 32'h80014321);
                req_valid = 1'b0;
                break;
            end
            if (req_valid && req_ready) acc_cnt++;
        end
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) rv_cnt++;
        end
        check_eq("hold.accepts", acc_cnt, 1);
        check_eq("hold.resps", rv_cnt, 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
